// File: rtl/qpp_interleaver.sv
// qpp_interleaver: LTE turbo QPP interleaver; loads one code block serially, streams it back as c(PI(i)).
// Addresses come from a multiplier-free second-order recursion with conditional-subtract modulo.
module qpp_interleaver (
    input  logic clk,
    input  logic reset,
    input  logic vld_crc,
    input  logic rdy_out,
    input  logic cbs,
    input  logic data_in,
    output logic rdy_crc,
    output logic vld_out,
    output logic data_out
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, SEND} state_t;
    state_t state_q, state_d;
    logic ksel_q, ksel_d;
    logic [12:0] cnt_q, cnt_d, pi_q, pi_d, g_q, g_d, k_val, two_f2;
    logic vld_out_q, vld_out_d, data_out_q, data_out_d, rdy_crc_q, rdy_crc_d;
    logic mem_we, emit;
    logic [6143:0] mem_q;

    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b, input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, k}) ? 13'(s - {1'b0, k}) : s[12:0];
    endfunction

    always_comb begin
        k_val = ksel_q ? 13'd6144 : 13'd1056;
        two_f2 = ksel_q ? 13'd960 : 13'd132;
        state_d = state_q;
        ksel_d = ksel_q;
        cnt_d = cnt_q;
        pi_d = pi_q;
        g_d = g_q;
        vld_out_d = 1'b0;
        data_out_d = 1'b0;
        mem_we = 1'b0;
        emit = 1'b0;
        case (state_q)
            IDLE: if (rdy_crc_q && vld_crc) begin
                state_d = LOAD;
                ksel_d = cbs;
                cnt_d = '0;
                pi_d = '0;
                g_d = cbs ? 13'd743 : 13'd83;
            end
            LOAD: begin
                mem_we = 1'b1;
                cnt_d = cnt_q + 13'd1;
                if (cnt_q == k_val - 13'd1) begin
                    state_d = WAIT;
                    cnt_d = '0;
                end
            end
            WAIT: if (rdy_out) begin
                state_d = SEND;
                emit = 1'b1;
            end
            SEND: if (cnt_q == k_val) state_d = IDLE;
                  else emit = 1'b1;
        endcase
        // Output register is fed from the address prepared one cycle ahead, hiding the read.
        if (emit) begin
            vld_out_d = 1'b1;
            data_out_d = mem_q[pi_q];
            cnt_d = cnt_q + 13'd1;
            pi_d = mod_add(pi_q, g_q, k_val);
            g_d = mod_add(g_q, two_f2, k_val);
        end
        rdy_crc_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ksel_q <= 1'b0;
            cnt_q <= '0;
            pi_q <= '0;
            g_q <= '0;
            vld_out_q <= 1'b0;
            data_out_q <= 1'b0;
            rdy_crc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ksel_q <= ksel_d;
            cnt_q <= cnt_d;
            pi_q <= pi_d;
            g_q <= g_d;
            vld_out_q <= vld_out_d;
            data_out_q <= data_out_d;
            rdy_crc_q <= rdy_crc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cnt_q] <= data_in;
    end

    assign rdy_crc = rdy_crc_q;
    assign vld_out = vld_out_q;
    assign data_out = data_out_q;
endmodule

// File: tb/tb_qpp_interleaver.sv
// tb_qpp_interleaver: directed and random blocks checked against a direct-formula QPP model.
module tb_qpp_interleaver;
    logic clk = 1'b0, reset = 1'b1, vld_crc = 1'b0, rdy_out = 1'b1, cbs = 1'b0, data_in = 1'b0;
    logic rdy_crc, vld_out, data_out;
    int n_assert = 0, n_fail = 0;
    bit in_bits[6144];
    bit out_bits[6144];

    qpp_interleaver dut (
        .clk(clk), .reset(reset), .vld_crc(vld_crc), .rdy_out(rdy_out), .cbs(cbs),
        .data_in(data_in), .rdy_crc(rdy_crc), .vld_out(vld_out), .data_out(data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int kof(input int ks);
        return ks != 0 ? 6144 : 1056;
    endfunction

    function automatic int qpp(input int k, input int i);
        longint f1, f2;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        return int'((f1 * i + f2 * i * i) % k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int ks, input int nbits);
        chk("rdy_crc_idle", {31'd0, rdy_crc}, 1);
        vld_crc = 1'b1;
        cbs = ks[0];
        @(negedge clk);
        vld_crc = 1'b0;
        chk("rdy_crc_busy", {31'd0, rdy_crc}, 0);
        for (int n = 0; n < nbits; n++) begin
            data_in = in_bits[n];
            cbs = 1'($urandom);
            @(negedge clk);
        end
        data_in = 1'b0;
    endtask

    task automatic collect(output int w, output int len);
        w = 0;
        while (vld_out !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        len = 0;
        while (vld_out === 1'b1 && len < 7000) begin
            out_bits[len] = data_out;
            len++;
            @(negedge clk);
        end
        chk("data_out_idle", {31'd0, data_out}, 0);
    endtask

    task automatic run(input string tag, input int ks);
        int w, l;
        load(ks, kof(ks));
        collect(w, l);
        chk({tag, "_start"}, w, 1);
        chk({tag, "_len"}, l, kof(ks));
    endtask

    task automatic clear_in();
        for (int n = 0; n < 6144; n++) in_bits[n] = 1'b0;
    endtask

    task automatic rand_in();
        for (int n = 0; n < 6144; n++) in_bits[n] = 1'($urandom);
    endtask

    task automatic cmp_model(input string tag, input int ks);
        int k, bad;
        k = kof(ks);
        bad = 0;
        for (int i = 0; i < k; i++) if (out_bits[i] != in_bits[qpp(k, i)]) bad++;
        chk({tag, "_bad_bits"}, bad, 0);
    endtask

    task automatic onehot(input string tag, input int ks, input int idx, input int exp_pos);
        int ones, pos;
        clear_in();
        in_bits[idx] = 1'b1;
        run(tag, ks);
        ones = 0;
        pos = -1;
        for (int i = 0; i < kof(ks); i++) if (out_bits[i]) begin ones++; pos = i; end
        chk({tag, "_ones"}, ones, 1);
        chk({tag, "_pos"}, pos, exp_pos);
    endtask

    initial begin
        int w, l, hi, ones, idx, pos;
        repeat (3) begin
            @(negedge clk);
            chk("rst_vld_out", {31'd0, vld_out}, 0);
            chk("rst_data_out", {31'd0, data_out}, 0);
        end
        chk("rst_rdy_crc", {31'd0, rdy_crc}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, rdy_crc}, 1);

        onehot("k1056_i83", 0, 83, 1);
        onehot("k1056_i298", 0, 298, 2);
        onehot("k1056_i645", 0, 645, 3);

        clear_in();
        in_bits[743] = 1'b1;
        in_bits[2446] = 1'b1;
        run("k6144_two", 1);
        ones = 0;
        for (int i = 0; i < 6144; i++) ones += int'(out_bits[i]);
        chk("k6144_ones", ones, 2);
        chk("k6144_out1", {31'd0, out_bits[1]}, 1);
        chk("k6144_out2", {31'd0, out_bits[2]}, 1);

        for (int t = 0; t < 4; t++) begin
            idx = $urandom_range(1055);
            pos = -1;
            for (int j = 0; j < 1056; j++) if (qpp(1056, j) == idx) pos = j;
            onehot("walk", 0, idx, pos);
        end

        rand_in();
        run("rand1056", 0);
        cmp_model("rand1056", 0);

        rand_in();
        run("rand6144", 1);
        cmp_model("rand6144", 1);

        rand_in();
        rdy_out = 1'b0;
        load(0, 1056);
        hi = 0;
        repeat (50) begin
            if (vld_out !== 1'b0) hi++;
            @(negedge clk);
        end
        chk("wait_hold", hi, 0);
        rdy_out = 1'b1;
        collect(w, l);
        chk("wait_start", w, 1);
        chk("wait_len", l, 1056);
        chk("wait_first_bit", {31'd0, out_bits[0]}, {31'd0, in_bits[0]});
        cmp_model("wait_blk", 0);

        rand_in();
        load(0, 300);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_load_vld", {31'd0, vld_out}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_load_rdy", {31'd0, rdy_crc}, 1);

        load(0, 1056);
        w = 0;
        while (vld_out !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (100) @(negedge clk);
        chk("send_active", {31'd0, vld_out}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_send_vld", {31'd0, vld_out}, 0);
        chk("rst_send_data", {31'd0, data_out}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_send_rdy", {31'd0, rdy_crc}, 1);

        rand_in();
        run("post_rst", 0);
        cmp_model("post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
